bin_bcd_seg7_display: RTL

//  Parametrised, sequential binary-to-7-segment display driver for an N-digit

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/bin_bcd_seg7_display.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the binary-to-BCD 7-segment display driver.
// Segment encoding is {g,f,e,d,c,b,a}, active-low (0 lights a segment).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Segment patterns for decimal digits; entry k holds the code for digit k.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // 10**n as a 64-bit value, used to size the largest displayable number.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational decoder from one BCD digit to an active-low 7-segment pattern.
// Codes 10..15 never come out of the converter; they map to a blank digit.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_digit,
  output logic [6:0] seg
);

  // Table lookup with blank as the fallback for non-decimal codes.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd_digit)
      4'd0: seg = SEG_TABLE[0];
      4'd1: seg = SEG_TABLE[1];
      4'd2: seg = SEG_TABLE[2];
      4'd3: seg = SEG_TABLE[3];
      4'd4: seg = SEG_TABLE[4];
      4'd5: seg = SEG_TABLE[5];
      4'd6: seg = SEG_TABLE[6];
      4'd7: seg = SEG_TABLE[7];
      4'd8: seg = SEG_TABLE[8];
      4'd9: seg = SEG_TABLE[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_bcd_seg7_display.sv
// Sequential binary -> BCD -> 7-segment driver using a double-dabble engine
// that consumes one input bit per cycle. Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank digits above the most significant non-zero
//                           digit (units digit always shown).
// Handshake: a value is accepted on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, and the source must hold in_valid and
// in_value stable until that edge. Outputs update together with a one-cycle
// done pulse and otherwise hold, so the display never flickers.
module bin_bcd_seg7_display
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   disp,
  output logic [1:0]            state_dbg
);

  localparam int              ACC_W    = 4 * DIGITS;
  localparam int              CNT_W    = $clog2(BIN_W + 1);
  localparam logic [63:0]     DEC_MAX  = pow10(DIGITS) - 64'd1;
  localparam logic [63:0]     BIN_MAX  = (64'd1 << BIN_W) - 64'd1;
  localparam logic [63:0]     MAX_VAL  = (DEC_MAX < BIN_MAX) ? DEC_MAX : BIN_MAX;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);

  state_t                   state, state_next;
  logic [BIN_W-1:0]         sr;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_adj;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_pend;
  logic [DIGITS-1:0][6:0]   seg_raw;
  logic [7*DIGITS-1:0]      disp_next;
  logic [63:0]              in_ext;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign in_ext    = {{(64-BIN_W){1'b0}}, in_value};

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: accept in IDLE, shift BIN_W cycles, one latch cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every accumulator digit that is 5 or more.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      bcd_to_seg7 u_dec (
        .bcd_digit (acc[4*g +: 4]),
        .seg       (seg_raw[g])
      );
    end
  endgenerate

  // Assemble the display word: optional leading-zero blanking, dashes on overflow.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;
    seen_nz   = 1'b0;
    disp_next = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (acc[4*k +: 4] != 4'd0) seen_nz = 1'b1;
      if (seen_nz || (k == 0)) disp_next[7*k +: 7] = seg_raw[k];
      else                     disp_next[7*k +: 7] = SEG_BLANK;
    end
`else
    disp_next = '0;
    for (int k = 0; k < DIGITS; k++) disp_next[7*k +: 7] = seg_raw[k];
`endif
    if (ovf_pend) disp_next = {DIGITS{SEG_DASH}};
  end

  // Datapath: capture on accept, shift while converting, publish in LATCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      disp     <= {DIGITS{SEG_BLANK}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr       <= in_value;
            acc      <= '0;
            cnt      <= CNT_INIT;
            ovf_pend <= (in_ext > MAX_VAL);
          end
        end
        SHIFT: begin
          {acc, sr} <= {acc_adj[ACC_W-2:0], sr, 1'b0};
          cnt       <= cnt - CNT_W'(1);
        end
        LATCH: begin
          bcd      <= acc;
          overflow <= ovf_pend;
          disp     <= disp_next;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
